// File: rtl/viterbi_frame_ctrl_if.sv
// Controller-side bundle for the Viterbi frame sequencer: deinterleaver symbol
// handshake, PMU enable/clear, TBU launch/done and frame status.
interface viterbi_frame_ctrl_if #(
  parameter int LEN_W = 12
);
  logic             iStart;
  logic [LEN_W-1:0] iFrameLen;
  logic             iSymValid;
  logic             oSymReady;
  logic             oPmuEN;
  logic             oPmuClr;
  logic             iMinFound;
  logic             oTbStart;
  logic             oTbFinal;
  logic             iTbDone;
  logic [LEN_W-1:0] oSymCount;
  logic             oBusy;
  logic             oDone;
  logic             oErr;

  modport slave (
    input  iStart, iFrameLen, iSymValid, iMinFound, iTbDone,
    output oSymReady, oPmuEN, oPmuClr, oTbStart, oTbFinal, oSymCount,
           oBusy, oDone, oErr
  );

  modport master (
    output iStart, iFrameLen, iSymValid, iMinFound, iTbDone,
    input  oSymReady, oPmuEN, oPmuClr, oTbStart, oTbFinal, oSymCount,
           oBusy, oDone, oErr
  );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame-level sequencer for the 64-state K=7 Viterbi decoder: gates symbol
// intake, clears path metrics, launches tracebacks and closes each frame.
module viterbi_frame_ctrl #(
  parameter int LEN_W      = 12,
  parameter int TB_TIMEOUT = 255
) (
  input logic              iClk,
  input logic              iRst_n,
  viterbi_frame_ctrl_if.slave bus
);

  localparam int TO_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    FINAL_TB,
    DONE
  } stateT;

  stateT            state;
  stateT            stateNxt;
  logic [LEN_W-1:0] lenQ;
  logic [LEN_W-1:0] symCount;
  logic             tbBusy;
  logic [TO_W-1:0]  toCnt;
  logic             tbStartQ;
  logic             tbFinalQ;
  logic             errQ;

  logic startOk;
  logic symReady;
  logic symFire;
  logic lastSym;
  logic launchMin;
  logic launchFinal;
  logic overrun;
  logic toRun;
  logic timeout;

  assign startOk   = (state == IDLE) && bus.iStart && (bus.iFrameLen != '0);
  assign symReady  = (state == RUN) && !tbStartQ;
  assign symFire   = symReady && bus.iSymValid;
  assign lastSym   = symFire && ((symCount + LEN_W'(1)) == lenQ);
  assign launchMin = bus.iMinFound && ((state == RUN) || (state == DRAIN));
  // A done coinciding with a new launch is not an overrun: the new launch wins.
  assign overrun   = launchMin && tbBusy && !bus.iTbDone;
  assign toRun     = tbBusy || (state == FINAL_TB);
  assign timeout   = toRun && !bus.iTbDone && !launchMin &&
                     (toCnt == TO_W'(TB_TIMEOUT - 1));

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= stateNxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    stateNxt    = state;
    launchFinal = 1'b0;
    case (state)
      IDLE:     if (startOk) stateNxt = CLEAR;
      CLEAR:    stateNxt = RUN;
      RUN:      if (lastSym) stateNxt = DRAIN;
      DRAIN: begin
        if (!tbBusy && !bus.iMinFound) begin
          launchFinal = 1'b1;
          stateNxt    = FINAL_TB;
        end
      end
      FINAL_TB: if (bus.iTbDone || timeout) stateNxt = DONE;
      DONE:     stateNxt = IDLE;
      default:  stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      lenQ     <= '0;
      symCount <= '0;
      tbBusy   <= 1'b0;
      toCnt    <= '0;
      tbStartQ <= 1'b0;
      tbFinalQ <= 1'b0;
      errQ     <= 1'b0;
    end else begin
      tbStartQ <= launchMin || launchFinal;
      tbFinalQ <= launchFinal;

      if (startOk) begin
        lenQ     <= bus.iFrameLen;
        symCount <= '0;
      end else if (symFire) begin
        symCount <= symCount + LEN_W'(1);
      end

      // A timed-out traceback is abandoned so DRAIN cannot wait on it forever.
      if (startOk)                      tbBusy <= 1'b0;
      else if (launchMin)               tbBusy <= 1'b1;
      else if (bus.iTbDone || timeout)  tbBusy <= 1'b0;

      if (!toRun || bus.iTbDone || launchMin || timeout) toCnt <= '0;
      else                                               toCnt <= toCnt + TO_W'(1);

      if (startOk)                 errQ <= 1'b0;
      else if (overrun || timeout) errQ <= 1'b1;
    end
  end

  assign bus.oSymReady = symReady;
  assign bus.oPmuEN    = symFire;
  assign bus.oPmuClr   = (state == CLEAR);
  assign bus.oTbStart  = tbStartQ;
  assign bus.oTbFinal  = tbFinalQ;
  assign bus.oSymCount = symCount;
  assign bus.oBusy     = (state != IDLE);
  assign bus.oDone     = (state == DONE);
  assign bus.oErr      = errQ;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl: nominal frame, throttling, overrun,
// traceback timeout, ignored starts and mid-frame reset.
module tb_viterbi_frame_ctrl;

  logic iClk;
  logic iRst_n;

  viterbi_frame_ctrl_if #(.LEN_W(12)) bus ();

  viterbi_frame_ctrl #(.LEN_W(12), .TB_TIMEOUT(255)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int nChecks;
  int nFail;

  int nPmuEn;
  int nEnNoValid;
  int nClr;
  int nTbStart;
  int nTbFinal;
  int nDone;
  int cyc;
  int finalCyc;
  int doneCyc;
  int errAtDone;
  int errBeforeDone;
  int prevErr;
  int tbuAuto;
  int tbuDelay;
  int tbuTimer;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clrStats();
    nPmuEn     = 0;
    nEnNoValid = 0;
    nClr       = 0;
    nTbStart   = 0;
    nTbFinal   = 0;
    nDone      = 0;
  endtask

  // Sample outputs on the falling edge, then drive the next cycle's inputs
  // just after the rising edge; a simple TBU model answers oTbStart.
  task automatic tick();
    @(negedge iClk);
    if (bus.oPmuEN) nPmuEn++;
    if (bus.oPmuEN && !bus.iSymValid) nEnNoValid++;
    if (bus.oPmuClr) nClr++;
    if (bus.oTbStart) begin
      nTbStart++;
      if (bus.oTbFinal) begin
        nTbFinal++;
        finalCyc = cyc;
      end
      if (tbuAuto != 0) tbuTimer = tbuDelay;
    end
    if (bus.oDone) begin
      nDone++;
      doneCyc       = cyc;
      errAtDone     = int'(bus.oErr);
      errBeforeDone = prevErr;
    end
    prevErr = int'(bus.oErr);
    cyc++;
    @(posedge iClk);
    #1;
    bus.iStart    = 1'b0;
    bus.iMinFound = 1'b0;
    bus.iTbDone   = 1'b0;
    if (tbuTimer > 0) begin
      tbuTimer--;
      if (tbuTimer == 0) bus.iTbDone = 1'b1;
    end
  endtask

  task automatic startFrame(input int len);
    bus.iFrameLen = 12'(len);
    bus.iStart    = 1'b1;
    tick();
  endtask

  task automatic runToDone(input string tag, input int maxCyc);
    int c;
    c = 0;
    while (nDone == 0 && c < maxCyc) begin
      tick();
      c++;
    end
    check(tag, 32'(nDone), 32'd1);
  endtask

  initial begin
    nChecks = 0; nFail = 0; cyc = 0; prevErr = 0;
    finalCyc = 0; doneCyc = 0; errAtDone = 0; errBeforeDone = 0;
    tbuAuto = 1; tbuDelay = 10; tbuTimer = 0;
    clrStats();
    iRst_n        = 1'b0;
    bus.iStart    = 1'b0;
    bus.iFrameLen = '0;
    bus.iSymValid = 1'b0;
    bus.iMinFound = 1'b0;
    bus.iTbDone   = 1'b0;

    // Reset state
    #2;
    check("rst_busy",  32'(bus.oBusy),     32'd0);
    check("rst_ready", 32'(bus.oSymReady), 32'd0);
    check("rst_count", 32'(bus.oSymCount), 32'd0);
    check("rst_err",   32'(bus.oErr),      32'd0);
    check("rst_done",  32'(bus.oDone),     32'd0);
    repeat (2) @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    tick();

    // Nominal 96-pair frame with three intermediate tracebacks
    clrStats();
    bus.iSymValid = 1'b1;
    startFrame(96);
    check("t1_clr_pulse", 32'(bus.oPmuClr),   32'd1);
    check("t1_clr_ready", 32'(bus.oSymReady), 32'd0);
    check("t1_clr_busy",  32'(bus.oBusy),     32'd1);
    for (int c = 0; c < 400 && nDone == 0; c++) begin
      if (c == 20 || c == 50 || c == 80) bus.iMinFound = 1'b1;
      tick();
    end
    check("t1_done_cnt", 32'(nDone),      32'd1);
    check("t1_pmu_en",   32'(nPmuEn),     32'd96);
    check("t1_count",    32'(bus.oSymCount), 32'd96);
    check("t1_tbstart",  32'(nTbStart),   32'd4);
    check("t1_tbfinal",  32'(nTbFinal),   32'd1);
    check("t1_clr_cnt",  32'(nClr),       32'd1);
    check("t1_err",      32'(bus.oErr),   32'd0);
    check("t1_idle",     32'(bus.oBusy),  32'd0);

    // Throttled 40-pair frame
    clrStats();
    bus.iSymValid = 1'b0;
    startFrame(40);
    for (int c = 0; c < 1000 && nDone == 0; c++) begin
      bus.iSymValid = 1'($urandom_range(0, 1));
      tick();
    end
    check("t2_done_cnt",  32'(nDone),      32'd1);
    check("t2_pmu_en",    32'(nPmuEn),     32'd40);
    check("t2_en_novalid", 32'(nEnNoValid), 32'd0);
    check("t2_count",     32'(bus.oSymCount), 32'd40);

    // Overrun: second minimum while the TBU is still busy
    clrStats();
    tbuAuto = 0;
    bus.iSymValid = 1'b1;
    startFrame(30);
    for (int c = 0; c < 16; c++) begin
      if (c == 5) bus.iMinFound = 1'b1;
      if (c == 10) begin
        check("t3_err_pre", 32'(bus.oErr), 32'd0);
        bus.iMinFound = 1'b1;
      end
      if (c == 15) begin
        check("t3_err_ovr",  32'(bus.oErr),  32'd1);
        check("t3_tbstarts", 32'(nTbStart), 32'd2);
        bus.iTbDone = 1'b1;
      end
      tick();
    end
    tbuAuto = 1;
    runToDone("t3_done_cnt", 300);
    check("t3_err_sticky", 32'(bus.oErr),   32'd1);
    check("t3_tbstart",    32'(nTbStart),   32'd3);
    check("t3_count",      32'(bus.oSymCount), 32'd30);

    // Final traceback timeout; the accepted start also clears oErr
    clrStats();
    tbuAuto = 0;
    startFrame(10);
    check("t4_err_clr", 32'(bus.oErr), 32'd0);
    runToDone("t4_done_cnt", 600);
    check("t4_to_cycles",  32'(doneCyc - finalCyc), 32'd255);
    check("t4_err_at_done", 32'(errAtDone),     32'd1);
    check("t4_err_before",  32'(errBeforeDone), 32'd0);
    check("t4_idle",        32'(bus.oBusy),     32'd0);
    check("t4_err_sticky",  32'(bus.oErr),      32'd1);

    // Zero-length start ignored; start mid-RUN ignored
    clrStats();
    tbuAuto = 1;
    bus.iFrameLen = '0;
    bus.iStart    = 1'b1;
    tick();
    tick();
    check("t5_len0_busy", 32'(bus.oBusy), 32'd0);
    check("t5_len0_clr",  32'(nClr),      32'd0);
    startFrame(20);
    for (int c = 0; c < 200 && nDone == 0; c++) begin
      if (c == 8) begin
        bus.iFrameLen = 12'd5;
        bus.iStart    = 1'b1;
      end
      tick();
    end
    check("t5_done_cnt", 32'(nDone),      32'd1);
    check("t5_count",    32'(bus.oSymCount), 32'd20);
    check("t5_pmu_en",   32'(nPmuEn),     32'd20);
    check("t5_clr_cnt",  32'(nClr),       32'd1);
    check("t5_err",      32'(bus.oErr),   32'd0);

    // Asynchronous reset at oSymCount=17, then a clean frame
    clrStats();
    startFrame(50);
    for (int c = 0; c < 100 && bus.oSymCount != 12'd17; c++) tick();
    check("t6_reach17", 32'(bus.oSymCount), 32'd17);
    #2;
    iRst_n = 1'b0;
    #1;
    check("t6_busy",    32'(bus.oBusy),     32'd0);
    check("t6_count",   32'(bus.oSymCount), 32'd0);
    check("t6_ready",   32'(bus.oSymReady), 32'd0);
    check("t6_pmu_en",  32'(bus.oPmuEN),    32'd0);
    check("t6_tbstart", 32'(bus.oTbStart),  32'd0);
    check("t6_pmuclr",  32'(bus.oPmuClr),   32'd0);
    check("t6_done",    32'(bus.oDone),     32'd0);
    repeat (3) tick();
    iRst_n = 1'b1;
    tick();
    check("t6_no_done", 32'(nDone), 32'd0);
    clrStats();
    startFrame(12);
    runToDone("t6_new_done", 200);
    check("t6_new_count", 32'(bus.oSymCount), 32'd12);
    check("t6_new_pmu_en", 32'(nPmuEn),       32'd12);
    check("t6_new_err",    32'(bus.oErr),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
- Frame-level sequencer for the 64-state K=7 Viterbi decoder (BMU -> PMU -> TBU).
- Accepts soft-symbol pairs from the deinterleaver over a valid/ready handshake and gates the PMU write-enable.
- Clears path metrics at frame start and launches traceback on every PMU minimum-found pulse.
- Issues a final zero-state traceback after the tail symbols, then signals frame completion.

Parameters:
- LEN_W, 12, width of frame length / symbol counter (max 4095 symbol pairs per frame).
- TB_TIMEOUT, 255, cycles allowed for a traceback before the sticky error flag is set (8-bit counter).

Ports:
- iClk  in  1  clock
- iRst_n  in  1  asynchronous active-low reset
- iStart  in  1  frame start request; sampled in IDLE only
- iFrameLen  in  LEN_W  symbol pairs in the frame, tail included; latched on accepted iStart
- iSymValid  in  1  upstream symbol pair valid
- oSymReady  out  1  controller can accept a symbol pair this cycle
- oPmuEN  out  1  PMU/BMU enable; equals iSymValid & oSymReady (combinational)
- oPmuClr  out  1  one-cycle synchronous clear of PMU/ACS metrics
- iMinFound  in  1  PMU minimum-PM-found pulse
- oTbStart  out  1  one-cycle traceback launch
- oTbFinal  out  1  valid with oTbStart; traceback from state 0 (tail-terminated)
- iTbDone  in  1  TBU finished the current traceback (one-cycle pulse)
- oSymCount  out  LEN_W  symbol pairs accepted in the current frame
- oBusy  out  1  high in every state except IDLE
- oDone  out  1  one-cycle frame-complete pulse
- oErr  out  1  sticky error flag; cleared only on an accepted iStart

Behaviour:
- Reset values: state IDLE, all outputs 0, internal tbBusy=0, timeout counter 0. Reset mid-frame aborts immediately with no oDone.
- IDLE:
  - iStart=1 with iFrameLen!=0 -> latch the length, clear oSymCount and oErr, go to CLEAR.
  - iStart=1 with iFrameLen=0 -> ignored; stay in IDLE.
- CLEAR: oPmuClr=1 for exactly one cycle -> RUN. oSymReady stays 0.
- RUN:
  - oSymReady=1 except in the cycle oTbStart is asserted.
  - Each handshake (iSymValid & oSymReady) increments oSymCount.
  - When the increment reaches the latched length -> go to DRAIN on the next edge; oSymReady drops the same edge.
- Traceback launch (RUN and DRAIN):
  - iMinFound in cycle N -> oTbStart=1, oTbFinal=0 in cycle N+1; tbBusy is set.
  - iTbDone clears tbBusy.
  - If iMinFound arrives while tbBusy=1 -> set oErr (overrun) and still issue oTbStart; the TBU restarts.
- DRAIN:
  - Wait until tbBusy=0 and no iMinFound is pending.
  - Then oTbStart=1, oTbFinal=1 for one cycle -> FINAL_TB.
- FINAL_TB: wait for iTbDone -> DONE.
- DONE: oDone=1 for one cycle -> IDLE.
- Timeout:
  - The counter runs while tbBusy=1 or in FINAL_TB, and resets on iTbDone.
  - Reaching TB_TIMEOUT sets oErr.
  - In FINAL_TB, a timeout also forces DONE so the decoder cannot hang.
- Simultaneous events:
  - iTbDone and iMinFound in the same cycle: the new launch wins, so tbBusy stays 1 and there is no overrun.
  - iStart outside IDLE is ignored.
  - iSymValid outside RUN is not accepted.
- oSymCount holds its final value until the next accepted iStart.
- All state and output registers sit on posedge iClk / negedge iRst_n.

Test Plan:
- Reset then iStart with iFrameLen=96 and iSymValid held high:
  - oPmuClr pulses in the cycle after start; 96 handshakes occur; oSymCount=96.
  - Three iMinFound pulses (iTbDone 10 cycles after each) produce three oTbStart, oTbFinal=0.
  - Then one oTbStart with oTbFinal=1; after iTbDone, oDone pulses; oErr=0.
- Throttling: iSymValid toggled pseudo-randomly for iFrameLen=40 -> oPmuEN asserts exactly 40 times, never while iSymValid=0.
- Overrun: second iMinFound while iTbDone is withheld -> oErr=1 and second oTbStart issued; oErr clears on the next iStart.
- Timeout: withhold iTbDone in FINAL_TB -> oErr=1 after 255 cycles, then oDone pulses and oBusy falls.
- iStart with iFrameLen=0 -> oBusy stays 0. iStart pulsed mid-RUN -> ignored, count unaffected.
- iRst_n asserted at oSymCount=17 -> all outputs 0 asynchronously, state IDLE, no oDone. A new frame then runs normally.
